// File: rtl/alu_seq.sv
// ============================================================================
// Module   : alu_seq
// Purpose  : Issue/write-back sequencer for the 32-bit data-processing ALU:
//            condition check, opcode translation, flag and register write-back.
//            Optional SEQ_PERF_CNT_EN adds saturating exec/skip counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_cond,
    input  logic [3:0]  in_opcode,
    input  logic        in_s,
    input  logic [3:0]  in_rd,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_shift_carry,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_shift_carry,
    output logic        alu_cf,
    output logic        alu_vf,
    input  logic [31:0] alu_f,
    input  logic [3:0]  alu_nzcv,
    output logic        rf_we,
    output logic [3:0]  rf_addr,
    output logic [31:0] rf_data,
    output logic [3:0]  nzcv,
    output logic        skip,
    output logic        done
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0] exec_cnt,
    output logic [15:0] skip_cnt
`endif
);

    localparam logic [3:0] c_op_tst = 4'b1000;
    localparam logic [3:0] c_op_teq = 4'b1001;
    localparam logic [3:0] c_op_cmp = 4'b1010;
    localparam logic [3:0] c_op_cmn = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_cond_ok;
    logic        w_accept;
    logic        w_reject;

    logic [3:0]  r_nzcv;
    logic [3:0]  r_alu_op;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic        r_alu_sc;
    logic        r_s;
    logic [3:0]  r_rd;
    logic        r_is_cmp;
    logic [3:0]  r_rf_addr;
    logic [31:0] r_rf_data;
    logic        r_skip;

    // ARM condition evaluation; flags ordered N,Z,C,V from bit 3 down.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c && !z;
            4'b1001: cond_pass = !c || z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z && (n == v);
            4'b1101: cond_pass = z || (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // Compares reuse the matching logical/arithmetic ALU operation.
    function automatic logic [3:0] map_op(input logic [3:0] op);
        case (op)
            c_op_tst: map_op = 4'b0000;
            c_op_teq: map_op = 4'b0001;
            c_op_cmp: map_op = 4'b0010;
            c_op_cmn: map_op = 4'b0100;
            default:  map_op = op;
        endcase
    endfunction

    assign w_cond_ok = cond_pass(in_cond, r_nzcv);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (w_cond_ok) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_EXEC;
                    end else begin
                        w_reject    = 1'b1;
                    end
                end
            end
            ST_EXEC: w_state_nxt = ST_WB;
            ST_WB:   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The latched instruction fields double as the held ALU operand drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_op <= 4'd0;
            r_alu_a  <= 32'd0;
            r_alu_b  <= 32'd0;
            r_alu_sc <= 1'b0;
            r_s      <= 1'b0;
            r_rd     <= 4'd0;
            r_is_cmp <= 1'b0;
        end else if (w_accept) begin
            r_alu_op <= map_op(in_opcode);
            r_alu_a  <= in_a;
            r_alu_b  <= in_b;
            r_alu_sc <= in_shift_carry;
            r_s      <= in_s;
            r_rd     <= in_rd;
            r_is_cmp <= (in_opcode[3:2] == 2'b10);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nzcv    <= 4'd0;
            r_rf_addr <= 4'd0;
            r_rf_data <= 32'd0;
        end else if (r_state == ST_EXEC) begin
            if (r_s) begin
                r_nzcv <= alu_nzcv;
            end
            if (!r_is_cmp) begin
                r_rf_addr <= r_rd;
                r_rf_data <= alu_f;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skip <= 1'b0;
        end else begin
            r_skip <= w_reject;
        end
    end

    assign in_ready        = (r_state == ST_IDLE);
    assign alu_op          = r_alu_op;
    assign alu_a           = r_alu_a;
    assign alu_b           = r_alu_b;
    assign alu_shift_carry = r_alu_sc;
    assign alu_cf          = r_nzcv[1];
    assign alu_vf          = r_nzcv[0];
    assign rf_we           = (r_state == ST_WB) && !r_is_cmp;
    assign rf_addr         = r_rf_addr;
    assign rf_data         = r_rf_data;
    assign nzcv            = r_nzcv;
    assign skip            = r_skip;
    assign done            = (r_state == ST_WB);

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] r_exec_cnt;
    logic [15:0] r_skip_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exec_cnt <= 16'd0;
            r_skip_cnt <= 16'd0;
        end else begin
            if (done && (r_exec_cnt != 16'hFFFF)) begin
                r_exec_cnt <= r_exec_cnt + 16'd1;
            end
            if (r_skip && (r_skip_cnt != 16'hFFFF)) begin
                r_skip_cnt <= r_skip_cnt + 16'd1;
            end
        end
    end

    assign exec_cnt = r_exec_cnt;
    assign skip_cnt = r_skip_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Directed self-checking bench for alu_seq with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cond;
    logic [3:0]  in_opcode;
    logic        in_s;
    logic [3:0]  in_rd;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_shift_carry;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_shift_carry;
    logic        alu_cf;
    logic        alu_vf;
    logic [31:0] alu_f;
    logic [3:0]  alu_nzcv;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [31:0] rf_data;
    logic [3:0]  nzcv;
    logic        skip;
    logic        done;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0] exec_cnt;
    logic [15:0] skip_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [3:0] c_al  = 4'b1110;
    localparam logic [3:0] c_ne  = 4'b0001;
    localparam logic [3:0] c_eq  = 4'b0000;
    localparam logic [3:0] c_nv  = 4'b1111;
    localparam logic [3:0] c_sub = 4'b0010;
    localparam logic [3:0] c_add = 4'b0100;
    localparam logic [3:0] c_cmp = 4'b1010;
    localparam logic [3:0] c_mov = 4'b1101;

    alu_seq dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_cond         (in_cond),
        .in_opcode       (in_opcode),
        .in_s            (in_s),
        .in_rd           (in_rd),
        .in_a            (in_a),
        .in_b            (in_b),
        .in_shift_carry  (in_shift_carry),
        .alu_op          (alu_op),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_shift_carry (alu_shift_carry),
        .alu_cf          (alu_cf),
        .alu_vf          (alu_vf),
        .alu_f           (alu_f),
        .alu_nzcv        (alu_nzcv),
        .rf_we           (rf_we),
        .rf_addr         (rf_addr),
        .rf_data         (rf_data),
        .nzcv            (nzcv),
        .skip            (skip),
        .done            (done)
`ifdef SEQ_PERF_CNT_EN
        ,
        .exec_cnt        (exec_cnt),
        .skip_cnt        (skip_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {c, v, sum} of x + y + cin
    function automatic logic [33:0] add3(input logic [31:0] x, input logic [31:0] y, input logic cin);
        logic [32:0] s;
        logic        v;
        s = {1'b0, x} + {1'b0, y} + {32'd0, cin};
        v = (x[31] == y[31]) && (s[31] != x[31]);
        add3 = {s[32], v, s[31:0]};
    endfunction

    // Behavioural ALU: returns {nzcv, f}
    function automatic logic [35:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic sc,
                                              input logic cf, input logic vf);
        logic [33:0] t;
        logic [31:0] r;
        logic        c;
        logic        v;
        c = sc;
        v = vf;
        t = '0;
        r = '0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a ^ b;
            4'b0010: t = add3(a, ~b, 1'b1);
            4'b0011: t = add3(b, ~a, 1'b1);
            4'b0100: t = add3(a, b, 1'b0);
            4'b0101: t = add3(a, b, cf);
            4'b0110: t = add3(a, ~b, cf);
            4'b0111: t = add3(b, ~a, cf);
            4'b1100: r = a | b;
            4'b1101: r = b;
            4'b1110: r = a & ~b;
            4'b1111: r = ~b;
            default: r = '0;
        endcase
        if (op[3:2] == 2'b00 && op[1:0] != 2'b00 || op[3:2] == 2'b01 || op == 4'b0010) begin
            r = t[31:0];
            c = t[33];
            v = t[32];
        end
        if (op == 4'b0001) begin
            r = a ^ b;
            c = sc;
            v = vf;
        end
        alu_model = {r[31], (r == 32'd0), c, v, r};
    endfunction

    always @(negedge clk) begin
        logic [35:0] res;
        res      = alu_model(alu_op, alu_a, alu_b, alu_shift_carry, alu_cf, alu_vf);
        alu_nzcv = res[35:32];
        alu_f    = res[31:0];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] cond, input logic [3:0] op, input logic s,
                         input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b);
        in_cond   = cond;
        in_opcode = op;
        in_s      = s;
        in_rd     = rd;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
    endtask

    logic [8:0] rdy_seq;
    logic [8:0] we_seq;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_cond = '0;
        in_opcode = '0;
        in_s = 1'b0;
        in_rd = '0;
        in_a = '0;
        in_b = '0;
        in_shift_carry = 1'b0;
        alu_f = '0;
        alu_nzcv = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", in_ready, 1'b1);
        check_eq("rst_nzcv", nzcv, 4'b0000);
        check_eq("rst_we", rf_we, 1'b0);
        check_eq("rst_aluop", alu_op, 4'b0000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rel_ready", in_ready, 1'b1);
        check_eq("rel_done", done, 1'b0);

        // ADD overflow into the sign bit
        issue(c_al, c_add, 1'b1, 4'd3, 32'h7FFF_FFFF, 32'h0000_0001);
        check_eq("add_aluop", alu_op, 4'b0100);
        check_eq("add_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        check_eq("add_nzcv", nzcv, 4'b1001);
        check_eq("add_we", rf_we, 1'b1);
        check_eq("add_addr", rf_addr, 4'd3);
        check_eq("add_data", rf_data, 32'h8000_0000);
        check_eq("add_done", done, 1'b1);
        @(posedge clk);
        #1;
        check_eq("add_ready2", in_ready, 1'b1);
        check_eq("add_we_off", rf_we, 1'b0);

        // CMP equal operands
        issue(c_al, c_cmp, 1'b1, 4'd4, 32'd5, 32'd5);
        check_eq("cmp_aluop", alu_op, 4'b0010);
        check_eq("cmp_cf_old", alu_cf, 1'b0);
        check_eq("cmp_vf_old", alu_vf, 1'b1);
        @(posedge clk);
        #1;
        check_eq("cmp_nzcv", nzcv, 4'b0110);
        check_eq("cmp_we", rf_we, 1'b0);
        check_eq("cmp_done", done, 1'b1);
        check_eq("cmp_cf_new", alu_cf, 1'b1);
        @(posedge clk);
        #1;

        // SUB NE fails with Z set
        issue(c_ne, c_sub, 1'b1, 4'd2, 32'd9, 32'd1);
        check_eq("ne_skip", skip, 1'b1);
        check_eq("ne_ready", in_ready, 1'b1);
        check_eq("ne_aluop", alu_op, 4'b0010);
        check_eq("ne_nzcv", nzcv, 4'b0110);
        @(posedge clk);
        #1;
        check_eq("ne_skip_off", skip, 1'b0);
        check_eq("ne_done", done, 1'b0);

        // MOV EQ passes, S=0 leaves flags alone
        issue(c_eq, c_mov, 1'b0, 4'd7, 32'hDEAD_BEEF, 32'h0000_1234);
        check_eq("mov_aluop", alu_op, 4'b1101);
        @(posedge clk);
        #1;
        check_eq("mov_we", rf_we, 1'b1);
        check_eq("mov_addr", rf_addr, 4'd7);
        check_eq("mov_data", rf_data, 32'h0000_1234);
        check_eq("mov_nzcv", nzcv, 4'b0110);
        @(posedge clk);
        #1;

        // back-to-back ADDs with in_valid held high
        in_cond   = c_al;
        in_opcode = c_add;
        in_s      = 1'b0;
        in_rd     = 4'd5;
        in_a      = 32'h0000_0100;
        in_b      = 32'h0000_0023;
        in_valid  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            rdy_seq[i] = in_ready;
            we_seq[i]  = rf_we;
            if (i == 6) in_valid = 1'b0;
        end
        check_eq("b2b_ready", {23'd0, rdy_seq}, 32'b1_0010_0100);
        check_eq("b2b_we", {23'd0, we_seq}, 32'b0_1001_0010);
        check_eq("b2b_data", rf_data, 32'h0000_0123);
        check_eq("b2b_nzcv", nzcv, 4'b0110);

        // reset during EXEC discards the instruction
        issue(c_al, c_add, 1'b1, 4'd9, 32'h7FFF_FFFF, 32'h0000_0001);
        check_eq("rx_exec", in_ready, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rx_ready", in_ready, 1'b1);
        check_eq("rx_nzcv", nzcv, 4'b0000);
        check_eq("rx_we", rf_we, 1'b0);
        check_eq("rx_done", done, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rx_we2", rf_we, 1'b0);
        check_eq("rx_done2", done, 1'b0);
        check_eq("rx_nzcv2", nzcv, 4'b0000);
        check_eq("rx_ready2", in_ready, 1'b1);

        // NV never executes
        issue(c_nv, c_mov, 1'b1, 4'd1, 32'd0, 32'h55);
        check_eq("nv_skip", skip, 1'b1);
        check_eq("nv_aluop", alu_op, 4'b0000);
        @(posedge clk);
        #1;
        check_eq("nv_skip_off", skip, 1'b0);
        check_eq("nv_we", rf_we, 1'b0);
`ifdef SEQ_PERF_CNT_EN
        check_eq("cnt_skip", skip_cnt, 16'd1);
        check_eq("cnt_exec", exec_cnt, 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
